// File: rtl/tinyalu_ng_pkg.sv
// Shared types and register map for the next-generation TinyALU.
// Covers the opcode and FSM enums, the register offsets and field positions, and a saturating counter helper.
package tinyalu_ng_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_SUB = 3'b101,
        OP_SHL = 3'b110,
        OP_CAT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_MULW  = 2'd2
    } state_e;

    localparam logic [31:0] REG_CMD    = 32'h0;
    localparam logic [31:0] REG_SRC    = 32'h4;
    localparam logic [31:0] REG_RESULT = 32'h8;
    localparam logic [31:0] REG_STATUS = 32'hC;

    localparam int CMD_START_BIT   = 8;
    localparam int CMD_BUSY_BIT    = 16;
    localparam int SRC_B_LSB       = 16;
    localparam int STATUS_DROP_LSB = 16;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/tinyalu_ng_mult_pipe.sv
// Fixed-latency unsigned multiplier: the product and its valid flag appear MUL_LAT cycles after in_valid.
// Only a shift register is used, so no stalls or backpressure are possible.
module alu_mult_pipe
    import tinyalu_ng_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MUL_LAT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    output logic                out_valid,
    output logic [2*DATA_W-1:0] product
);
    localparam int R_W = 2 * DATA_W;

    logic [MUL_LAT-1:0] valid_sr;
    logic [R_W-1:0]     prod_sr [MUL_LAT];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_sr <= '0;
            // NOTE: the data stages are cleared too; a flushed pipe must not leak a stale product onto result.
            for (int i = 0; i < MUL_LAT; i++) prod_sr[i] <= '0;
        end else begin
            valid_sr   <= {valid_sr[MUL_LAT-2:0], in_valid};
            prod_sr[0] <= R_W'(A) * R_W'(B);
            for (int i = 1; i < MUL_LAT; i++) prod_sr[i] <= prod_sr[i-1];
        end
    end

    assign out_valid = valid_sr[MUL_LAT-1];
    assign product   = prod_sr[MUL_LAT-1];

endmodule

// File: rtl/tinyalu_ng.sv
// TinyALU-NG top level: accepts starts from hardware or the register bus, runs a one-cycle ALU or the multiply pipe,
// and exposes results and saturating done/drop counters through the register bus.
module tinyalu_ng
    import tinyalu_ng_pkg::*;
#(
    parameter int          DATA_W      = 8,
    parameter int          MUL_LAT     = 4,
    parameter logic [31:0] ADDR_OFFSET = 32'h0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [2:0]          op,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] result,
    input  logic                valid,
    input  logic                read,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wmask,
    output logic [31:0]         rdata
);
    localparam int                R_W        = 2 * DATA_W;
    localparam int                SH_W       = $clog2(DATA_W) + 1;
    localparam int                CNT_W      = $clog2(MUL_LAT);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MUL_LAT - 1);
    localparam logic [31:0]       SRC_FIELDS = 32'({DATA_W{1'b1}}) | (32'({DATA_W{1'b1}}) << SRC_B_LSB);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, b_q;
    op_e                 op_q;
    logic [R_W-1:0]      result_q, alu_res, done_val;
    logic [2:0]          op_reg_q;
    logic [31:0]         src_q;
    logic [15:0]         done_cnt, drop_cnt;

    // Register bus decode
    logic [31:0] rel, bmask, src_new;
    logic        bus_wr, hit_cmd, hit_src, hit_result, hit_status;
    logic [2:0]  op_reg_new;

    assign rel        = addr - ADDR_OFFSET;
    assign hit_cmd    = (rel == REG_CMD);
    assign hit_src    = (rel == REG_SRC);
    assign hit_result = (rel == REG_RESULT);
    assign hit_status = (rel == REG_STATUS);
    assign bus_wr     = valid && !read;
    assign bmask      = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
    assign src_new    = ((src_q & ~bmask) | (wdata & bmask)) & SRC_FIELDS;
    assign op_reg_new = wmask[0] ? wdata[2:0] : op_reg_q;

    // Accept arbitration: a hardware start always beats a bus start in the same cycle.
    logic              bus_start, can_accept, hw_take, bus_take, launch, mul_launch;
    op_e               sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [1:0]        drop_inc;

    assign bus_start  = bus_wr && hit_cmd && wmask[1] && wdata[CMD_START_BIT];
    assign can_accept = !busy || done;
    assign hw_take    = start && can_accept;
    assign bus_take   = bus_start && !start && can_accept;
    assign sel_op     = hw_take ? op_e'(op) : op_e'(op_reg_new);
    assign sel_a      = hw_take ? A : src_q[DATA_W-1:0];
    assign sel_b      = hw_take ? B : src_q[SRC_B_LSB +: DATA_W];
    assign launch     = (hw_take || bus_take) && (sel_op != OP_NOP);
    assign mul_launch = launch && (sel_op == OP_MUL);
    assign drop_inc   = {1'b0, start && !can_accept} + {1'b0, bus_start && !bus_take};

    logic           mul_valid;
    logic [R_W-1:0] mul_product;

    alu_mult_pipe #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) u_mult (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (mul_launch),
        .A         (sel_a),
        .B         (sel_b),
        .out_valid (mul_valid),
        .product   (mul_product)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = R_W'(a_q) + R_W'(b_q);
            OP_AND:  alu_res = R_W'(a_q & b_q);
            OP_XOR:  alu_res = R_W'(a_q ^ b_q);
            OP_SUB:  alu_res = R_W'(a_q) - R_W'(b_q);
            OP_SHL:  alu_res = R_W'(a_q) << b_q[SH_W-1:0];
            OP_CAT:  alu_res = {a_q, b_q};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_EXEC1: state_d = ST_IDLE;
            ST_MULW: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (launch) begin
            state_d = (sel_op == OP_MUL) ? ST_MULW : ST_EXEC1;
            cnt_d   = '0;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_EXEC1) || mul_valid;
    assign done_val = (state_q == ST_EXEC1) ? alu_res : mul_product;
    assign result   = done ? done_val : result_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_NOP;
            result_q <= '0;
            op_reg_q <= '0;
            src_q    <= '0;
            done_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (launch) begin
                a_q  <= sel_a;
                b_q  <= sel_b;
                op_q <= sel_op;
            end
            if (done) result_q <= done_val;
            if (bus_wr && hit_cmd) op_reg_q <= op_reg_new;
            if (bus_wr && hit_src) src_q <= src_new;
            // A STATUS clear wins over an increment landing in the same cycle.
            if (bus_wr && hit_status && (wmask != 4'b0)) begin
                done_cnt <= '0;
                drop_cnt <= '0;
            end else begin
                done_cnt <= sat_add(done_cnt, {1'b0, done});
                drop_cnt <= sat_add(drop_cnt, drop_inc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (valid && read) begin
            if (hit_cmd)         rdata <= (32'(op_reg_q) | (32'(busy) << CMD_BUSY_BIT));
            else if (hit_src)    rdata <= src_q;
            else if (hit_result) rdata <= 32'(result);
            else if (hit_status) rdata <= {drop_cnt, done_cnt};
            else                 rdata <= '0;
        end
    end

endmodule

// File: tb/tb_tinyalu_ng.sv
// Scoreboard bench for tinyalu_ng: stimulus pushes expected results from a plain-arithmetic model;
// an independent negedge monitor pops and compares whenever done is presented.
module tb_tinyalu_ng;
    localparam int          DW = 8;
    localparam int          ML = 4;
    localparam logic [31:0] AO = 32'h0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] A, B;
    logic [2:0]    op;
    logic          start, busy, done;
    logic [2*DW-1:0] result;
    logic          valid, read;
    logic [31:0]   addr, wdata, rdata;
    logic [3:0]    wmask;

    tinyalu_ng #(.DATA_W(DW), .MUL_LAT(ML), .ADDR_OFFSET(AO)) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .B(B), .op(op), .start(start),
        .busy(busy), .done(done), .result(result),
        .valid(valid), .read(read), .addr(addr), .wdata(wdata), .wmask(wmask), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned exp;
        int          due;
        int          issue;
    } txn_t;

    txn_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          free_at = 0;
    int unsigned last_res = 0;
    int          done_m = 0;
    int          drop_m = 0;
    logic [31:0] src_m = '0;
    logic [2:0]  cmdop_m = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned ref_alu(input int unsigned a, input int unsigned b, input int opc);
        longint unsigned mod, r;
        mod = 64'd1 << (2 * DW);
        case (opc)
            1: r = a + b;
            2: r = a & b;
            3: r = a ^ b;
            4: r = longint'(a) * longint'(b);
            5: r = mod + a - b;
            6: r = longint'(a) << (b & ((1 << ($clog2(DW) + 1)) - 1));
            7: r = (longint'(a) << DW) | b;
            default: r = 0;
        endcase
        return int'(r % mod);
    endfunction

    task automatic model_accept(input int unsigned a, input int unsigned b, input int opc);
        int lat;
        if (opc == 0) return;
        lat = (opc == 4) ? ML : 1;
        sb.push_back('{exp: ref_alu(a, b, opc), due: cyc + lat, issue: cyc});
        free_at = cyc + lat;
        done_m++;
    endtask

    // Decides acceptance for the starts present in the current cycle.
    task automatic model_starts(input bit hw, input int unsigned a, input int unsigned b, input int opc, input bit bus);
        bit can;
        can = (cyc >= free_at);
        if (hw) begin
            if (!can) drop_m++;
            else model_accept(a, b, opc);
        end
        if (bus) begin
            if (hw || !can) drop_m++;
            else model_accept(src_m[DW-1:0], src_m[16 +: DW], int'(cmdop_m));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bus_wr(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] m, output bit bstart);
        logic [31:0] bm;
        bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        valid = 1'b1; read = 1'b0; addr = ad; wdata = d; wmask = m;
        bstart = 1'b0;
        if (ad == AO + 32'h4) src_m = ((src_m & ~bm) | (d & bm)) & 32'h00FF_00FF;
        if (ad == AO) begin
            if (m[0]) cmdop_m = d[2:0];
            bstart = m[1] && d[8];
        end
        if (ad == AO + 32'hC && m != 4'b0) begin
            drop_m = 0;
            done_m = 0;
        end
    endtask

    task automatic bus_wr(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] m);
        bit bstart;
        drive_bus_wr(ad, d, m, bstart);
        model_starts(1'b0, 0, 0, 0, bstart);
        tick();
        valid = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] ad, output logic [31:0] d);
        valid = 1'b1; read = 1'b1; addr = ad;
        tick();
        valid = 1'b0; read = 1'b0;
        d = rdata;
    endtask

    task automatic hw_op(input int unsigned a, input int unsigned b, input int opc);
        A = DW'(a); B = DW'(b); op = 3'(opc); start = 1'b1;
        model_starts(1'b1, a, b, opc, 1'b0);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (ML + 2) tick();
    endtask

    task automatic check_status(input string name);
        logic [31:0] d;
        bus_rd(AO + 32'hC, d);
        check(name, d, {16'(drop_m), 16'(done_m)});
    endtask

    // Monitor: busy every cycle, done timing against the scoreboard, result value or hold.
    always @(negedge clk) begin : monitor
        bit due_now;
        if (reset_n) begin
            check("busy", 32'(busy), 32'((sb.size() > 0) && (cyc > sb[0].issue)));
            due_now = (sb.size() > 0) && (sb[0].due == cyc);
            check("done", 32'(done), 32'(due_now));
            if (due_now) begin
                check("result", 32'(result), sb[0].exp);
                last_res = sb[0].exp;
                void'(sb.pop_front());
            end else begin
                check("result_hold", 32'(result), last_res);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] d;
        bit          bstart;
        reset_n = 1'b0; A = '0; B = '0; op = '0; start = 1'b0;
        valid = 1'b0; read = 1'b0; addr = '0; wdata = '0; wmask = '0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        reset_n = 1'b1;
        tick();

        // ADD with carry into the upper half
        hw_op(8'hFF, 8'h01, 1);
        wait_idle();

        // MUL with three overlapping starts dropped, then a back-to-back accept on the done cycle
        bus_wr(AO + 32'hC, 32'h0, 4'hF);
        hw_op(8'hFF, 8'hFF, 4);
        hw_op(1, 2, 1);
        hw_op(3, 4, 2);
        hw_op(5, 6, 4);
        hw_op(8'h11, 8'h22, 1);
        wait_idle();
        check_status("status_mul_drops");

        // SUB wrap, SHL, CAT back to back
        hw_op(5, 7, 5);
        hw_op(8'h81, 4, 6);
        hw_op(8'hAB, 8'hCD, 7);
        hw_op(8'h0F, 8'hF0, 3);
        hw_op(8'h01, 8'h0F, 6);
        wait_idle();

        // Bus-launched MUL
        bus_wr(AO + 32'h4, 32'h0003_0004, 4'hF);
        bus_wr(AO + 32'h0, 32'h0000_0104, 4'hF);
        wait_idle();
        bus_rd(AO + 32'h8, d);
        check("bus_result", d, 32'd12);
        bus_rd(AO + 32'h0, d);
        check("cmd_start_bit", 32'(d[8]), 32'h0);
        check("cmd_read", d, 32'h0000_0004);

        // Reset during MUL aborts it
        hw_op(9, 9, 4);
        tick();
        reset_n = 1'b0;
        tick(); tick();
        check("abort_done", 32'(done), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_result", 32'(result), 32'h0);
        reset_n = 1'b1;
        sb.delete();
        free_at = 0; drop_m = 0; done_m = 0; last_res = 0; src_m = '0; cmdop_m = '0;
        check_status("status_after_reset");
        hw_op(1, 2, 1);
        wait_idle();

        // Same-cycle hardware and bus start: hardware wins, bus start is counted as dropped
        bus_wr(AO + 32'h4, 32'h0005_0006, 4'hF);
        bus_wr(AO + 32'hC, 32'h0, 4'h1);
        A = 8'h10; B = 8'h20; op = 3'd1; start = 1'b1;
        drive_bus_wr(AO, 32'h0000_0103, 4'h3, bstart);
        model_starts(1'b1, 8'h10, 8'h20, 1, bstart);
        tick();
        start = 1'b0; valid = 1'b0;
        wait_idle();
        check_status("status_same_cycle");
        bus_rd(AO + 32'h8, d);
        check("hw_wins_result", d, 32'h30);
        bus_rd(AO + 32'h10, d);
        check("unmapped_read", d, 32'h0);

        // SRC register readback with partial byte masks
        for (int i = 0; i < 8; i++) begin
            bus_wr(AO + 32'h4, $urandom, 4'($urandom_range(0, 15)));
            bus_rd(AO + 32'h4, d);
            check("src_readback", d, src_m);
        end

        // Randomized hardware traffic with random gaps to provoke drops and back-to-back accepts
        bus_wr(AO + 32'hC, 32'hFFFF_FFFF, 4'hF);
        for (int i = 0; i < 250; i++) begin
            hw_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
            repeat ($urandom_range(0, ML)) tick();
        end
        wait_idle();
        check_status("status_random");
        bus_rd(AO + 32'h8, d);
        check("random_last_result", d, last_res);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
